if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_pkg.sv | 38 +++
 rtl/if_id_stage_load_use_detect.sv | 17 +
 rtl/if_id_stage.sv | 81 ++++++++
 tb/tb_if_id_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared CPU constants: instruction field positions, opcodes and the NOP word.
// Imported by IF/ID, control and ID/EX logic so field layout is defined once.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use hazard comparison between the load in ID/EX and the sources in IF/ID.
module load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rt,
  input  logic [4:0] Rs,
  input  logic [4:0] Rt,
  input  logic       Valid,
  output logic       hazard
);

  always_comb begin
    hazard = EX_MemRead & Valid & (reg_hit(EX_Rt, Rs) | reg_hit(EX_Rt, Rt));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush, stall/load-use hold, field decode and
// a saturating stall-cycle counter.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_i,
  input  logic [31:0] Instr_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_Rt_i,
  output logic [31:0] PC_o,
  output logic [31:0] PC4_o,
  output logic [31:0] Instr_o,
  output logic        Valid_o,
  output logic [5:0]  Opcode_o,
  output logic [4:0]  Rs_o,
  output logic [4:0]  Rt_o,
  output logic [4:0]  Rd_o,
  output logic [4:0]  Shamt_o,
  output logic [5:0]  Funct_o,
  output logic [15:0] Imm_o,
  output logic        Hazard_o,
  output logic        Bubble_o,
  output logic [15:0] StallCnt_o
);

  logic hazard;
  logic hold;

  always_comb begin
    Opcode_o = Instr_o[OPCODE_MSB:OPCODE_LSB];
    Rs_o     = Instr_o[RS_MSB:RS_LSB];
    Rt_o     = Instr_o[RT_MSB:RT_LSB];
    Rd_o     = Instr_o[RD_MSB:RD_LSB];
    Shamt_o  = Instr_o[SHAMT_MSB:SHAMT_LSB];
    Funct_o  = Instr_o[FUNCT_MSB:FUNCT_LSB];
    Imm_o    = Instr_o[IMM_MSB:IMM_LSB];
    PC4_o    = PC_o + 32'd4;
  end

  load_use_detect u_load_use_detect (
    .EX_MemRead (EX_MemRead_i),
    .EX_Rt      (EX_Rt_i),
    .Rs         (Rs_o),
    .Rt         (Rt_o),
    .Valid      (Valid_o),
    .hazard     (hazard)
  );

  always_comb begin
    Hazard_o = hazard;
    Bubble_o = hazard;
    hold     = Stall_i | hazard;
  end

  // Flush beats hold so a squashed slot never lingers behind a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_o       <= '0;
      Instr_o    <= NOP_INSTR;
      Valid_o    <= 1'b0;
      StallCnt_o <= '0;
    end else if (Flush_i) begin
      PC_o       <= PC_i;
      Instr_o    <= NOP_INSTR;
      Valid_o    <= 1'b0;
    end else if (hold) begin
      if (StallCnt_o != '1) StallCnt_o <= StallCnt_o + 16'd1;
    end else begin
      PC_o       <= PC_i;
      Instr_o    <= Instr_i;
      Valid_o    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: vector table plus hand-written corner sequences.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC_i = '0;
  logic [31:0] Instr_i = '0;
  logic        Stall_i = 1'b0;
  logic        Flush_i = 1'b0;
  logic        EX_MemRead_i = 1'b0;
  logic [4:0]  EX_Rt_i = '0;
  logic [31:0] PC_o, PC4_o, Instr_o;
  logic        Valid_o, Hazard_o, Bubble_o;
  logic [5:0]  Opcode_o, Funct_o;
  logic [4:0]  Rs_o, Rt_o, Rd_o, Shamt_o;
  logic [15:0] Imm_o, StallCnt_o;

  if_id_stage #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_i         (PC_i),
    .Instr_i      (Instr_i),
    .Stall_i      (Stall_i),
    .Flush_i      (Flush_i),
    .EX_MemRead_i (EX_MemRead_i),
    .EX_Rt_i      (EX_Rt_i),
    .PC_o         (PC_o),
    .PC4_o        (PC4_o),
    .Instr_o      (Instr_o),
    .Valid_o      (Valid_o),
    .Opcode_o     (Opcode_o),
    .Rs_o         (Rs_o),
    .Rt_o         (Rt_o),
    .Rd_o         (Rd_o),
    .Shamt_o      (Shamt_o),
    .Funct_o      (Funct_o),
    .Imm_o        (Imm_o),
    .Hazard_o     (Hazard_o),
    .Bubble_o     (Bubble_o),
    .StallCnt_o   (StallCnt_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] I1  = 32'h8C22_0004; // lw  $2,4($1)
  localparam logic [31:0] I2  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] I3  = 32'h0064_2820; // add $5,$3,$4

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        memread;
    logic [4:0]  rt;
    logic        hz;
    exp_t        post;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t        e;
    logic [31:0] w;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 1 want 0", tag);
      return;
    end
    e = sb.pop_front();
    w = e.instr;
    cmp({tag, ".pc"},    PC_o,       e.pc);
    cmp({tag, ".pc4"},   PC4_o,      e.pc + 32'd4);
    cmp({tag, ".instr"}, Instr_o,    e.instr);
    cmp({tag, ".valid"}, {31'd0, Valid_o}, {31'd0, e.valid});
    cmp({tag, ".cnt"},   {16'd0, StallCnt_o}, {16'd0, e.cnt});
    cmp({tag, ".op"},    {26'd0, Opcode_o}, {26'd0, w[31:26]});
    cmp({tag, ".rs"},    {27'd0, Rs_o},     {27'd0, w[25:21]});
    cmp({tag, ".rt"},    {27'd0, Rt_o},     {27'd0, w[20:16]});
    cmp({tag, ".rd"},    {27'd0, Rd_o},     {27'd0, w[15:11]});
    cmp({tag, ".shamt"}, {27'd0, Shamt_o},  {27'd0, w[10:6]});
    cmp({tag, ".funct"}, {26'd0, Funct_o},  {26'd0, w[5:0]});
    cmp({tag, ".imm"},   {16'd0, Imm_o},    {16'd0, w[15:0]});
  endtask

  initial begin
    //               pc            instr st fl mr rt  hz   post {pc, instr, valid, cnt}
    vecs[0]  = '{32'h40,       I1, 0, 0, 0, 5'd0, 0, '{32'h40,       I1,  1, 16'd0}};
    vecs[1]  = '{32'h44,       I2, 0, 0, 1, 5'd5, 0, '{32'h44,       I2,  1, 16'd0}};
    vecs[2]  = '{32'h48,       I3, 0, 0, 1, 5'd2, 1, '{32'h44,       I2,  1, 16'd1}};
    vecs[3]  = '{32'h48,       I3, 0, 0, 1, 5'd0, 0, '{32'h48,       I3,  1, 16'd1}};
    vecs[4]  = '{32'h4C,       I1, 0, 0, 1, 5'd3, 1, '{32'h48,       I3,  1, 16'd2}};
    vecs[5]  = '{32'h4C,       I1, 0, 0, 1, 5'd4, 1, '{32'h48,       I3,  1, 16'd3}};
    vecs[6]  = '{32'h4C,       I1, 1, 1, 0, 5'd0, 0, '{32'h4C,       NOP, 0, 16'd3}};
    vecs[7]  = '{32'h50,       I2, 0, 0, 1, 5'd1, 0, '{32'h50,       I2,  1, 16'd3}};
    vecs[8]  = '{32'h54,       I3, 1, 0, 0, 5'd0, 0, '{32'h50,       I2,  1, 16'd4}};
    vecs[9]  = '{32'h54,       I3, 0, 1, 1, 5'd2, 1, '{32'h54,       NOP, 0, 16'd4}};
    vecs[10] = '{32'hFFFF_FFFC, I1, 0, 0, 0, 5'd0, 0, '{32'hFFFF_FFFC, I1,  1, 16'd4}};

    // Reset state, held across a clock edge.
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{32'h0, NOP, 1'b0, 16'd0});
    check_out("reset");
    cmp("reset.hazard", {31'd0, Hazard_o}, 32'd0);
    cmp("reset.bubble", {31'd0, Bubble_o}, 32'd0);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      PC_i         = vecs[i].pc;
      Instr_i      = vecs[i].instr;
      Stall_i      = vecs[i].stall;
      Flush_i      = vecs[i].flush;
      EX_MemRead_i = vecs[i].memread;
      EX_Rt_i      = vecs[i].rt;
      #1;
      cmp($sformatf("row%0d.hazard", i), {31'd0, Hazard_o}, {31'd0, vecs[i].hz});
      cmp($sformatf("row%0d.bubble", i), {31'd0, Bubble_o}, {31'd0, vecs[i].hz});
      sb.push_back(vecs[i].post);
      @(posedge clk);
      #1;
      check_out($sformatf("row%0d", i));
    end
    cmp("wrap.pc4", PC4_o, 32'h0000_0000);

    // Long external stall: counter climbs from 4 and must saturate, not wrap.
    @(negedge clk);
    Stall_i      = 1'b1;
    Flush_i      = 1'b0;
    EX_MemRead_i = 1'b0;
    PC_i         = 32'h60;
    Instr_i      = I3;
    repeat (65540) @(posedge clk);
    #1;
    sb.push_back('{32'hFFFF_FFFC, I1, 1'b1, 16'hFFFF});
    check_out("sat");

    // Asynchronous reset in the middle of a stall with a live load-use hazard.
    @(negedge clk);
    EX_MemRead_i = 1'b1;
    EX_Rt_i      = 5'd2;
    #1;
    cmp("pre_reset.hazard", {31'd0, Hazard_o}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    sb.push_back('{32'h0, NOP, 1'b0, 16'd0});
    check_out("async_reset");
    cmp("async_reset.hazard", {31'd0, Hazard_o}, 32'd0);

    // First edge after release loads the incoming word.
    @(negedge clk);
    reset        = 1'b0;
    Stall_i      = 1'b0;
    EX_MemRead_i = 1'b0;
    EX_Rt_i      = '0;
    PC_i         = 32'h80;
    Instr_i      = I3;
    sb.push_back('{32'h80, I3, 1'b1, 16'd0});
    @(posedge clk);
    #1;
    check_out("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
